// File: rtl/lenet_argmax_2set.sv
// ---------------------------------------------------------------------------
// LenetArgmax2Set: final classification stage of the LeNet pipeline.
//
// The FC2 stage writes its class scores for two independent sets through an
// SRAM-style port (word address + active-low byte mask, one class per lane).
// This block keeps a private copy of every score. When fc2_done pulses, it
// scans the classes one per cycle, both sets side by side, and keeps the
// winning index and score for each set. The result is held under a
// valid/ready handshake.
//
// Ports
//   clk                 : clock, rising edge
//   srst                : asynchronous active-high reset
//   sram_write_enable_f : write strobe, active-low
//   sram_bytemask_f     : lane select, active-low (lane k -> class 4*addr+k)
//   sram_waddr_f        : word address
//   sram_wdata_f        : set-0 score byte
//   sram_wdata_f_1      : set-1 score byte
//   fc2_done            : one-cycle pulse, all scores have been written
//   result_valid        : winning classes/scores are available
//   result_ready        : consumer accepts the result
//   result_class0/1     : winning class index for set 0 / set 1
//   result_score0/1     : winning signed score for set 0 / set 1
//   overrun             : sticky, fc2_done seen while scanning or holding
// ---------------------------------------------------------------------------
module lenet_argmax_2set #(
  parameter int DATA_WIDTH = 8,
  parameter int CLASS_NUM  = 10
) (
  input  logic                  clk,
  input  logic                  srst,
  input  logic                  sram_write_enable_f,
  input  logic [3:0]            sram_bytemask_f,
  input  logic [1:0]            sram_waddr_f,
  input  logic [DATA_WIDTH-1:0] sram_wdata_f,
  input  logic [DATA_WIDTH-1:0] sram_wdata_f_1,
  input  logic                  fc2_done,
  output logic                  result_valid,
  input  logic                  result_ready,
  output logic [3:0]            result_class0,
  output logic [3:0]            result_class1,
  output logic [DATA_WIDTH-1:0] result_score0,
  output logic [DATA_WIDTH-1:0] result_score1,
  output logic                  overrun
);

  // The most negative signed value. Empty score slots hold it, so they can
  // only win when every slot is still empty.
  localparam logic [DATA_WIDTH-1:0] SCORE_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  localparam logic [3:0]            LAST_IDX  = 4'(CLASS_NUM - 1);

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    OUT
  } state_t;

  state_t                        r_state;
  logic [3:0]                    r_idx;
  logic signed [DATA_WIDTH-1:0]  r_score0 [CLASS_NUM];
  logic signed [DATA_WIDTH-1:0]  r_score1 [CLASS_NUM];
  logic signed [DATA_WIDTH-1:0]  r_max0;
  logic signed [DATA_WIDTH-1:0]  r_max1;
  logic [3:0]                    r_maxIdx0;
  logic [3:0]                    r_maxIdx1;
  logic                          r_valid;
  logic [3:0]                    r_resClass0;
  logic [3:0]                    r_resClass1;
  logic [DATA_WIDTH-1:0]         r_resScore0;
  logic [DATA_WIDTH-1:0]         r_resScore1;
  logic                          r_overrun;

  logic [CLASS_NUM-1:0]          w_hit;
  logic signed [DATA_WIDTH-1:0]  w_cur0;
  logic signed [DATA_WIDTH-1:0]  w_cur1;
  logic                          w_take0;
  logic                          w_take1;
  logic signed [DATA_WIDTH-1:0]  w_nextMax0;
  logic signed [DATA_WIDTH-1:0]  w_nextMax1;
  logic [3:0]                    w_nextIdx0;
  logic [3:0]                    w_nextIdx1;

  // Each class decodes its own write hit: it is selected when the word
  // address matches its word and the mask bit of its lane is low. Classes
  // past CLASS_NUM have no slot, so writes to them are dropped here.
  always_comb begin
    w_hit = '0;
    for (int c = 0; c < CLASS_NUM; c++) begin
      w_hit[c] = !sram_write_enable_f && (sram_waddr_f == 2'(c / 4)) &&
                 !sram_bytemask_f[c % 4];
    end
  end

  // Running max step for both sets. Index 0 always seeds the running max.
  // Later indices replace it only on a strictly greater signed score, so a
  // tie keeps the lower index.
  always_comb begin
    w_cur0     = r_score0[r_idx];
    w_cur1     = r_score1[r_idx];
    w_take0    = (r_idx == 4'd0) || (w_cur0 > r_max0);
    w_take1    = (r_idx == 4'd0) || (w_cur1 > r_max1);
    w_nextMax0 = w_take0 ? w_cur0 : r_max0;
    w_nextMax1 = w_take1 ? w_cur1 : r_max1;
    w_nextIdx0 = w_take0 ? r_idx : r_maxIdx0;
    w_nextIdx1 = w_take1 ? r_idx : r_maxIdx1;
  end

  // Main sequencer. In IDLE it captures writes, and a write in the same cycle
  // as fc2_done still lands before the scan starts. SCAN takes one class per
  // cycle and publishes the winners on the final index. OUT holds the result
  // until the handshake. The handshake edge also empties the score buffers
  // for the next image. A stray fc2_done outside IDLE only raises overrun.
  always_ff @(posedge clk or posedge srst) begin
    if (srst) begin
      r_state     <= IDLE;
      r_idx       <= 4'd0;
      r_max0      <= SCORE_MIN;
      r_max1      <= SCORE_MIN;
      r_maxIdx0   <= 4'd0;
      r_maxIdx1   <= 4'd0;
      r_valid     <= 1'b0;
      r_resClass0 <= 4'd0;
      r_resClass1 <= 4'd0;
      r_resScore0 <= SCORE_MIN;
      r_resScore1 <= SCORE_MIN;
      r_overrun   <= 1'b0;
      for (int c = 0; c < CLASS_NUM; c++) begin
        r_score0[c] <= SCORE_MIN;
        r_score1[c] <= SCORE_MIN;
      end
    end else begin
      case (r_state)
        IDLE: begin
          for (int c = 0; c < CLASS_NUM; c++) begin
            if (w_hit[c]) begin
              r_score0[c] <= sram_wdata_f;
              r_score1[c] <= sram_wdata_f_1;
            end
          end
          if (fc2_done) begin
            r_state <= SCAN;
            r_idx   <= 4'd0;
          end
        end

        SCAN: begin
          if (fc2_done) begin
            r_overrun <= 1'b1;
          end
          r_max0    <= w_nextMax0;
          r_max1    <= w_nextMax1;
          r_maxIdx0 <= w_nextIdx0;
          r_maxIdx1 <= w_nextIdx1;
          if (r_idx == LAST_IDX) begin
            r_resClass0 <= w_nextIdx0;
            r_resClass1 <= w_nextIdx1;
            r_resScore0 <= w_nextMax0;
            r_resScore1 <= w_nextMax1;
            r_valid     <= 1'b1;
            r_idx       <= 4'd0;
            r_state     <= OUT;
          end else begin
            r_idx <= r_idx + 4'd1;
          end
        end

        OUT: begin
          if (fc2_done) begin
            r_overrun <= 1'b1;
          end
          if (result_ready) begin
            r_valid <= 1'b0;
            r_state <= IDLE;
            for (int c = 0; c < CLASS_NUM; c++) begin
              r_score0[c] <= SCORE_MIN;
              r_score1[c] <= SCORE_MIN;
            end
          end
        end

        default: begin
          r_state <= IDLE;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  assign result_valid  = r_valid;
  assign result_class0 = r_resClass0;
  assign result_class1 = r_resClass1;
  assign result_score0 = r_resScore0;
  assign result_score1 = r_resScore1;
  assign overrun       = r_overrun;

endmodule

// File: tb/tb_lenet_argmax_2set.sv
module tb_lenet_argmax_2set;

  localparam int DW = 8;
  localparam int CN = 10;

  logic          clk;
  logic          srst;
  logic          sram_write_enable_f;
  logic [3:0]    sram_bytemask_f;
  logic [1:0]    sram_waddr_f;
  logic [DW-1:0] sram_wdata_f;
  logic [DW-1:0] sram_wdata_f_1;
  logic          fc2_done;
  logic          result_valid;
  logic          result_ready;
  logic [3:0]    result_class0;
  logic [3:0]    result_class1;
  logic [DW-1:0] result_score0;
  logic [DW-1:0] result_score1;
  logic          overrun;

  int checks = 0;
  int errors = 0;

  // Behavioural copy of the two score buffers, in plain integers
  int m0[CN];
  int m1[CN];

  lenet_argmax_2set #(.DATA_WIDTH(DW), .CLASS_NUM(CN)) dut (
    .clk                 (clk),
    .srst                (srst),
    .sram_write_enable_f (sram_write_enable_f),
    .sram_bytemask_f     (sram_bytemask_f),
    .sram_waddr_f        (sram_waddr_f),
    .sram_wdata_f        (sram_wdata_f),
    .sram_wdata_f_1      (sram_wdata_f_1),
    .fc2_done            (fc2_done),
    .result_valid        (result_valid),
    .result_ready        (result_ready),
    .result_class0       (result_class0),
    .result_class1       (result_class1),
    .result_score0       (result_score0),
    .result_score1       (result_score1),
    .overrun             (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Empties the model buffers, as reset or a handshake does
  function automatic void clearModel();
    for (int i = 0; i < CN; i++) begin
      m0[i] = -128;
      m1[i] = -128;
    end
  endfunction

  // Expected result packed as {class0, score0, class1, score1}. The winner
  // is the largest value, and among equal values the first one in the list.
  task automatic modelArgmax(output logic [23:0] e);
    int mx0 = m0[0];
    int mx1 = m1[0];
    int c0  = 0;
    int c1  = 0;
    for (int i = 0; i < CN; i++) begin
      if (m0[i] > mx0) mx0 = m0[i];
      if (m1[i] > mx1) mx1 = m1[i];
    end
    for (int i = CN - 1; i >= 0; i--) begin
      if (m0[i] == mx0) c0 = i;
      if (m1[i] == mx1) c1 = i;
    end
    e = {4'(c0), 8'(mx0), 4'(c1), 8'(mx1)};
  endtask

  function automatic logic [23:0] observed();
    return {result_class0, result_score0, result_class1, result_score1};
  endfunction

  // Drives one write (optionally with fc2_done) for one cycle. It starts and
  // ends at a falling edge. When upd is set, the model applies the write.
  task automatic applyStimulus(input logic [1:0] a, input logic [3:0] m,
                               input logic [7:0] d0, input logic [7:0] d1,
                               input bit done, input bit upd);
    sram_write_enable_f = 1'b0;
    sram_waddr_f        = a;
    sram_bytemask_f     = m;
    sram_wdata_f        = d0;
    sram_wdata_f_1      = d1;
    fc2_done            = done;
    if (upd) begin
      for (int k = 0; k < 4; k++) begin
        int c = int'(a) * 4 + k;
        if (!m[k] && c < CN) begin
          m0[c] = int'($signed(d0));
          m1[c] = int'($signed(d1));
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
    sram_write_enable_f = 1'b1;
    sram_bytemask_f     = 4'hF;
    fc2_done            = 1'b0;
  endtask

  task automatic pulseDone();
    fc2_done = 1'b1;
    @(posedge clk);
    @(negedge clk);
    fc2_done = 1'b0;
  endtask

  // Counts cycles after the fc2_done edge until result_valid. The count is
  // 1 at the first falling edge after fc2_done. It gives up at 40.
  task automatic waitValid(input int start, output int lat);
    lat = start;
    while (result_valid !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic finishHandshake();
    result_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    result_ready = 1'b0;
    clearModel();
  endtask

  // Writes a fresh random score into every class, one lane per write
  task automatic writeAllRandom();
    for (int c = 0; c < CN; c++) begin
      applyStimulus(2'(c / 4), ~(4'b0001 << (c % 4)), 8'($urandom),
                    8'($urandom), 1'b0, 1'b1);
    end
  endtask

  task automatic test_reset();
    srst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (result_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_valid got %b want 0", result_valid);
    end
    checks++;
    if (observed() !== {4'd0, 8'h80, 4'd0, 8'h80}) begin
      errors++;
      $display("[TB] FAIL reset_outputs got %h want %h", observed(), {4'd0, 8'h80, 4'd0, 8'h80});
    end
    checks++;
    if (overrun !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_overrun got %b want 0", overrun);
    end
    srst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_directed();
    int s0[CN] = '{5, -3, 20, 7, 0, 1, 2, 3, 4, 19};
    int s1[CN] = '{1, 1, 1, 1, 1, 1, 1, 1, 100, 1};
    logic [23:0] e;
    int lat;
    for (int c = 0; c < CN; c++) begin
      applyStimulus(2'(c / 4), ~(4'b0001 << (c % 4)), 8'(s0[c]), 8'(s1[c]), 1'b0, 1'b1);
    end
    pulseDone();
    waitValid(1, lat);
    checks++;
    if (lat != 11) begin
      errors++;
      $display("[TB] FAIL directed_latency got %0d want 11", lat);
    end
    modelArgmax(e);
    checks++;
    if (observed() !== e || e !== {4'd2, 8'd20, 4'd8, 8'd100}) begin
      errors++;
      $display("[TB] FAIL directed_result got %h want %h", observed(), e);
    end
    finishHandshake();
  endtask

  task automatic test_ties();
    logic [23:0] e;
    int lat;
    // All-low masks write one byte to all four lanes. Classes 10 and 11 do
    // not exist, so their lanes must be dropped.
    applyStimulus(2'd0, 4'b0000, 8'(-7), 8'(-7), 1'b0, 1'b1);
    applyStimulus(2'd1, 4'b0000, 8'(-7), 8'(-7), 1'b0, 1'b1);
    applyStimulus(2'd2, 4'b0000, 8'(-7), 8'(-7), 1'b0, 1'b1);
    pulseDone();
    waitValid(1, lat);
    checks++;
    if (lat != 11) begin
      errors++;
      $display("[TB] FAIL ties_latency got %0d want 11", lat);
    end
    modelArgmax(e);
    checks++;
    if (observed() !== e) begin
      errors++;
      $display("[TB] FAIL ties_result got %h want %h", observed(), e);
    end
    finishHandshake();
  endtask

  task automatic test_backpressure();
    logic [23:0] e;
    int lat;
    writeAllRandom();
    pulseDone();
    waitValid(1, lat);
    checks++;
    if (lat != 11) begin
      errors++;
      $display("[TB] FAIL bp_latency got %0d want 11", lat);
    end
    modelArgmax(e);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (result_valid !== 1'b1 || observed() !== e) begin
        errors++;
        $display("[TB] FAIL bp_hold%0d got valid=%b %h want valid=1 %h", i, result_valid, observed(), e);
      end
      @(negedge clk);
    end
    result_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    result_ready = 1'b0;
    clearModel();
    checks++;
    if (result_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL bp_valid_fall got %b want 0", result_valid);
    end
    checks++;
    if (observed() !== e) begin
      errors++;
      $display("[TB] FAIL bp_retain got %h want %h", observed(), e);
    end
    // No writes since the handshake, so every slot must read as empty
    pulseDone();
    waitValid(1, lat);
    modelArgmax(e);
    checks++;
    if (lat != 11 || observed() !== e) begin
      errors++;
      $display("[TB] FAIL bp_empty got lat=%0d %h want lat=11 %h", lat, observed(), e);
    end
    finishHandshake();
  endtask

  task automatic test_overrun();
    logic [23:0] e;
    int lat;
    writeAllRandom();
    pulseDone();
    // Writes that arrive during SCAN must leave the buffers unchanged. The
    // second fc2_done arrives with the first write.
    applyStimulus(2'd2, 4'b1011, 8'h7F, 8'h7F, 1'b1, 1'b0);
    applyStimulus(2'd0, 4'b0000, 8'h7F, 8'h7F, 1'b0, 1'b0);
    checks++;
    if (overrun !== 1'b1) begin
      errors++;
      $display("[TB] FAIL overrun_set got %b want 1", overrun);
    end
    waitValid(3, lat);
    modelArgmax(e);
    checks++;
    if (lat != 11 || observed() !== e) begin
      errors++;
      $display("[TB] FAIL overrun_result got lat=%0d %h want lat=11 %h", lat, observed(), e);
    end
    finishHandshake();
    checks++;
    if (overrun !== 1'b1 || result_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL overrun_sticky got ovr=%b valid=%b want ovr=1 valid=0", overrun, result_valid);
    end
    srst = 1'b1;
    @(negedge clk);
    srst = 1'b0;
    clearModel();
    checks++;
    if (overrun !== 1'b0) begin
      errors++;
      $display("[TB] FAIL overrun_clear got %b want 0", overrun);
    end
  endtask

  task automatic test_abort();
    logic [23:0] e;
    int lat;
    writeAllRandom();
    pulseDone();
    repeat (4) @(negedge clk);
    srst = 1'b1;
    #1;
    clearModel();
    checks++;
    if (result_valid !== 1'b0 || observed() !== {4'd0, 8'h80, 4'd0, 8'h80} || overrun !== 1'b0) begin
      errors++;
      $display("[TB] FAIL abort_reset got valid=%b %h ovr=%b want valid=0 %h ovr=0", result_valid, observed(), overrun, {4'd0, 8'h80, 4'd0, 8'h80});
    end
    @(negedge clk);
    srst = 1'b0;
    @(negedge clk);
    writeAllRandom();
    pulseDone();
    waitValid(1, lat);
    modelArgmax(e);
    checks++;
    if (lat != 11 || observed() !== e) begin
      errors++;
      $display("[TB] FAIL abort_rerun got lat=%0d %h want lat=11 %h", lat, observed(), e);
    end
    finishHandshake();
  endtask

  task automatic test_random();
    logic [23:0] e;
    int lat;
    int n;
    for (int it = 0; it < 6; it++) begin
      n = int'($urandom_range(1, 8));
      // The last write of each burst lands together with fc2_done
      for (int w = 0; w < n; w++) begin
        applyStimulus(2'($urandom_range(0, 3)), 4'($urandom), 8'($urandom),
                      8'($urandom), (w == n - 1), 1'b1);
      end
      waitValid(1, lat);
      modelArgmax(e);
      checks++;
      if (lat != 11 || observed() !== e) begin
        errors++;
        $display("[TB] FAIL random%0d got lat=%0d %h want lat=11 %h", it, lat, observed(), e);
      end
      repeat ($urandom_range(0, 3)) @(negedge clk);
      finishHandshake();
      checks++;
      if (result_valid !== 1'b0) begin
        errors++;
        $display("[TB] FAIL random%0d_valid_fall got %b want 0", it, result_valid);
      end
    end
  endtask

  initial begin
    srst                = 1'b1;
    sram_write_enable_f = 1'b1;
    sram_bytemask_f     = 4'hF;
    sram_waddr_f        = 2'd0;
    sram_wdata_f        = '0;
    sram_wdata_f_1      = '0;
    fc2_done            = 1'b0;
    result_ready        = 1'b0;
    clearModel();
    test_reset();
    test_directed();
    test_ties();
    test_backpressure();
    test_overrun();
    test_abort();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lenet_argmax_2set.md
LENET_ARGMAX_2SET -- requirements
Module: lenet_argmax_2set

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, meaning the signed score width per class.
REQ-002 The block SHALL have parameter CLASS_NUM, default 10, meaning the number of classes scanned per set.
REQ-003 The block SHALL have one clock and an asynchronous, active-high reset; all flops SHALL use this single clock.
REQ-004 clk  input  1  clock; all state updates occur on the rising edge.
REQ-005 srst  input  1  asynchronous active-high reset.
REQ-006 sram_write_enable_f  input  1  SRAM F write strobe from the FC2 stage, active-low.
REQ-007 sram_bytemask_f  input  4  byte-lane mask, active-low; bit k low selects lane k.
REQ-008 sram_waddr_f  input  2  SRAM F word address.
REQ-009 sram_wdata_f  input  DATA_WIDTH  set-0 score byte.
REQ-010 sram_wdata_f_1  input  DATA_WIDTH  set-1 score byte.
REQ-011 fc2_done  input  1  single-cycle pulse: all FC2 scores have been written.
REQ-012 result_valid  output  1  both class results are available.
REQ-013 result_ready  input  1  consumer accepts the result.
REQ-014 result_class0 / result_class1  output  4 each  winning class index for set 0 and set 1.
REQ-015 result_score0 / result_score1  output  DATA_WIDTH each  winning signed score for set 0 and set 1.
REQ-016 overrun  output  1  sticky error flag: fc2_done arrived while the block was busy.

Function
REQ-017 Score buffers: two arrays of CLASS_NUM signed DATA_WIDTH registers, one per set; reset value 8'h80 (-128).
REQ-018 Capture: in IDLE, on a cycle with sram_write_enable_f==0, each lane k with sram_bytemask_f[k]==0 SHALL write class index c = 4*sram_waddr_f + k.
REQ-019 Capture data: set-0 array[c] takes sram_wdata_f and set-1 array[c] takes sram_wdata_f_1.
REQ-020 Multiple low mask bits SHALL write the same bytes to every selected lane; c >= CLASS_NUM SHALL be ignored.
REQ-021 Writes arriving outside IDLE SHALL be ignored, so the buffers stay frozen.
REQ-022 FSM states: IDLE, SCAN, OUT.
REQ-023 IDLE -> SCAN on fc2_done==1; a write and fc2_done in the same cycle SHALL both take effect, with the write captured before the scan.
REQ-024 SCAN: 4-bit index counter runs 0..CLASS_NUM-1, one class per cycle, with both sets compared in parallel.
REQ-025 Running max is initialised from class 0 at index 0; for index i>0 it updates only if score[i] > running max (signed, strict), so ties resolve to the lowest index.
REQ-026 SCAN -> OUT after index CLASS_NUM-1 is processed; with fc2_done high in cycle T, result_valid SHALL first be 1 in cycle T+CLASS_NUM+1 (T+11 by default).
REQ-027 OUT: result_valid=1; result_class0/1 and result_score0/1 SHALL hold stable until the handshake.
REQ-028 OUT -> IDLE on the cycle where result_valid && result_ready; the same edge SHALL reset both score arrays to 8'h80.
REQ-029 result_class*/result_score* SHALL retain their last values after the handshake; result_valid SHALL be 0 outside OUT.
REQ-030 fc2_done in SCAN or OUT SHALL be ignored for sequencing and SHALL set overrun=1, which holds until reset.
REQ-031 Comparisons SHALL be full DATA_WIDTH signed; no saturation or extension beyond DATA_WIDTH is stored.

Reset
REQ-032 srst=1 SHALL asynchronously force: state IDLE, counter 0, all scores 8'h80, result_valid 0, result_class0/1 0, result_score0/1 8'h80, overrun 0.
REQ-033 srst asserted mid-SCAN or mid-OUT SHALL abort the operation; after release the block SHALL accept new writes in IDLE.

Verification
REQ-034 Set-0 scores {5,-3,20,7,0,1,2,3,4,19} and set-1 all 1 except class 8 = 100, written via 3 words with one mask bit low per write, then fc2_done in cycle T -> result_valid rises at T+11 with class0=2, score0=20, class1=8, score1=100.
REQ-035 All ten scores equal to -7 -> class=0, score=-7 for both sets (tie resolves to lowest index).
REQ-036 result_ready held 0 for 5 cycles in OUT, then 1 -> outputs stable throughout, and result_valid falls the cycle after the handshake; a following fc2_done with no new writes -> class 0, score -128.
REQ-037 A write to waddr=2 with mask 4'b1011 (lane 2, c=10) plus a second fc2_done pulse during SCAN -> no buffer change, the result is unaffected, and overrun=1 until srst.
REQ-038 srst pulsed at scan index 4 -> result_valid=0, all outputs at reset values; a fresh write sequence plus fc2_done -> correct result at T+11.
